host_loader: RTL and testbench

Serial host-port controller that sequences all host accesses to the instruction and data caches of the tiny processor. It deserialises chip-select-framed bit streams on mosi into cache write commands or read-back requests, drives miso during read-back, and holds off processor start while a host transaction is in flight. It sits between the uio pins and the cache write/read ports, replacing the free-running shift buffer with a framed, length-checked, arbitrated transfer engine.

---
 rtl/host_loader.sv | 171 +++++++++++++++++
 tb/tb_host_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/host_loader.sv
`default_nettype none
// ============================================================================
// host_loader : framed serial host port sequencing icache/dcache accesses
// Revision    : 1.0
// ============================================================================
module host_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csi_n,
  input  logic              csd_n,
  input  logic              mosi,
  input  logic              proc_run,
  input  logic [DATA_W-1:0] rd_data,
  output logic              miso,
  output logic              wr_en,
  output logic              rd_en,
  output logic              tgt_sel,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              host_busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WDATA  = 3'd2,
    S_COMMIT = 3'd3,
    S_RFETCH = 3'd4,
    S_RSHIFT = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              tgt_q, tgt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  logic w_any_low, w_both_low, w_both_high;
  logic w_own_low, w_other_low, w_abort;

  assign w_any_low   = ~csi_n | ~csd_n;
  assign w_both_low  = ~csi_n & ~csd_n;
  assign w_both_high = csi_n & csd_n;
  assign w_own_low   = tgt_q ? ~csd_n : ~csi_n;
  assign w_other_low = tgt_q ? ~csi_n : ~csd_n;
  // Frame is lost if its own select drops or the other target is selected.
  assign w_abort     = ~w_own_low | w_other_low;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_both_low || (w_any_low && proc_run)) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (w_any_low) begin
          rw_d    = mosi;
          tgt_d   = ~csd_n;
          cnt_d   = CNT_W'(1);
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (w_abort) begin
          err_d   = 1'b1;
          state_d = w_both_high ? S_IDLE : S_DRAIN;
        end else begin
          addr_d = {addr_q[ADDR_W-2:0], mosi};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W)) begin
            cnt_d   = '0;
            state_d = rw_q ? S_WDATA : S_RFETCH;
          end
        end
      end
      S_WDATA: begin
        if (w_abort) begin
          err_d   = 1'b1;
          state_d = w_both_high ? S_IDLE : S_DRAIN;
        end else begin
          wdata_d = {wdata_q[DATA_W-2:0], mosi};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_DRAIN;
      end
      S_RFETCH: begin
        shift_d = rd_data;
        cnt_d   = '0;
        state_d = S_RSHIFT;
      end
      S_RSHIFT: begin
        if (w_abort) begin
          err_d   = 1'b1;
          state_d = w_both_high ? S_IDLE : S_DRAIN;
        end else begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Trailing bits are swallowed here until the host releases both selects.
        if (w_both_high) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      tgt_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
    end
  end

  assign miso      = (state_q == S_RSHIFT) & shift_q[DATA_W-1];
  assign wr_en     = (state_q == S_COMMIT);
  assign rd_en     = (state_q == S_RFETCH);
  assign tgt_sel   = tgt_q;
  assign addr      = addr_q;
  assign wr_data   = wdata_q;
  assign host_busy = (state_q != S_IDLE);
  assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_host_loader.sv
`default_nettype none
// ============================================================================
// tb_host_loader : randomized frame-level bench for host_loader
// Revision       : 1.0
// ============================================================================
module tb_host_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int MAXC   = 16384;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csi_n = 1'b1;
  logic              csd_n = 1'b1;
  logic              mosi = 1'b0;
  logic              proc_run = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              miso, wr_en, rd_en, tgt_sel, host_busy, frame_err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;

  // Cache contents as seen by the DUT, and the bench's own view of them.
  logic [7:0] mem     [0:1][0:15];
  logic [7:0] ref_mem [0:1][0:15];

  // Expected output timeline, indexed by the cycle following a given edge.
  bit         exp_wr   [0:MAXC-1];
  bit         exp_rd   [0:MAXC-1];
  bit         exp_err  [0:MAXC-1];
  bit         exp_busy [0:MAXC-1];
  bit         exp_miso [0:MAXC-1];
  bit         exp_tgt  [0:MAXC-1];
  logic [3:0] exp_addr [0:MAXC-1];
  logic [7:0] exp_wd   [0:MAXC-1];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic       last_tgt = 1'b0;
  logic [3:0] last_addr = '0;
  logic [7:0] last_wd = '0;
  logic [7:0] miso_byte = '0;
  int         miso_k = 8;

  host_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi),
    .proc_run(proc_run), .rd_data(rd_data), .miso(miso), .wr_en(wr_en),
    .rd_en(rd_en), .tgt_sel(tgt_sel), .addr(addr), .wr_data(wr_data),
    .host_busy(host_busy), .frame_err(frame_err)
  );

  assign rd_data = mem[tgt_sel][addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, want);
    end
  endtask

  // Per-cycle comparison against the timeline, plus the cache-side monitor.
  task automatic check_cycle();
    if (!rst_n) begin
      chk("reset_outputs", {miso, wr_en, rd_en, tgt_sel, addr, wr_data, host_busy, frame_err}, 0);
    end else begin
      chk("wr_en", wr_en, exp_wr[cyc]);
      chk("rd_en", rd_en, exp_rd[cyc]);
      chk("frame_err", frame_err, exp_err[cyc]);
      chk("host_busy", host_busy, exp_busy[cyc]);
      chk("miso", miso, exp_miso[cyc]);
      if (exp_wr[cyc]) begin
        chk("wr_tgt", tgt_sel, exp_tgt[cyc]);
        chk("wr_addr", addr, exp_addr[cyc]);
        chk("wr_data", wr_data, exp_wd[cyc]);
      end
      if (exp_rd[cyc]) begin
        chk("rd_tgt", tgt_sel, exp_tgt[cyc]);
        chk("rd_addr", addr, exp_addr[cyc]);
      end
    end
    if (miso_k < 8) begin
      miso_byte = {miso_byte[6:0], miso};
      miso_k++;
    end
    if (wr_en) begin
      wr_cnt++;
      last_tgt  = tgt_sel;
      last_addr = addr;
      last_wd   = wr_data;
      mem[tgt_sel][addr] = wr_data;
    end
    if (rd_en) begin
      rd_cnt++;
      miso_k = 0;
    end
    if (frame_err) err_cnt++;
  endtask

  // Present inputs for the next edge, check the current cycle, take the edge.
  task automatic step(input logic ci, input logic cd, input logic mo, input logic pr);
    csi_n = ci; csd_n = cd; mosi = mo; proc_run = pr;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal / release-abort, 1 abort by other select, 2 refused by proc_run,
  //       3 both selects low at start. n = edges the own select is low (before m).
  task automatic frame(input bit is_wr, input bit tgt, input logic [3:0] a,
                       input logic [7:0] d, input int n, input int mode,
                       input int m, input int gap);
    int e, need, ab, x, flen;
    logic [12:0] bits;
    logic [7:0]  rv;
    bit own, oth, mo, pr;
    e    = cyc + 1;
    need = is_wr ? 13 : 14;
    flen = is_wr ? 13 : 5;
    bits = {is_wr, a, d};
    rv   = ref_mem[tgt][a];
    if (mode >= 2) begin
      exp_err[e] = 1'b1;
      x = e + n;
    end else if (n < need) begin
      // A read released just before the fetch is only seen once shifting starts.
      ab = (!is_wr && n == 5) ? e + 6 : e + n;
      exp_err[ab] = 1'b1;
      if (mode == 1) x = (ab + 1 > e + n + m) ? ab + 1 : e + n + m;
      else           x = ab;
      if (!is_wr && n >= 5) begin
        exp_rd[e+4] = 1'b1; exp_tgt[e+4] = tgt; exp_addr[e+4] = a;
        for (int k = 0; k < 8; k++)
          if (e + 5 + k < ab) exp_miso[e+5+k] = rv[7-k];
      end
    end else begin
      x = (e + 14 > e + n) ? e + 14 : e + n;
      if (is_wr) begin
        exp_wr[e+12] = 1'b1; exp_tgt[e+12] = tgt; exp_addr[e+12] = a; exp_wd[e+12] = d;
        ref_mem[tgt][a] = d;
      end else begin
        exp_rd[e+4] = 1'b1; exp_tgt[e+4] = tgt; exp_addr[e+4] = a;
        for (int k = 0; k < 8; k++) exp_miso[e+5+k] = rv[7-k];
      end
    end
    for (int c = e; c < x; c++) exp_busy[c] = 1'b1;
    for (int o = 0; o <= x - e + gap; o++) begin
      own = (mode == 1) ? (o < n + m) : (o < n);
      oth = (mode == 3) ? (o < n) : (mode == 1 && o >= n && o < n + m);
      mo  = (o < flen) ? bits[12-o] : 1'($urandom_range(0, 1));
      pr  = (o == 0) ? (mode == 2) : 1'($urandom_range(0, 1));
      step(!(tgt ? oth : own), !(tgt ? own : oth), mo, pr);
    end
  endtask

  int w0, r0, e0, e;
  logic [12:0] rbits;

  initial begin
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 16; a++) begin
        mem[t][a]     = 8'((t * 16 + a) * 37) ^ 8'h5A;
        ref_mem[t][a] = 8'((t * 16 + a) * 37) ^ 8'h5A;
      end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Write icache addr 5 <- A5.
    w0 = wr_cnt; e0 = err_cnt;
    frame(1'b1, 1'b0, 4'h5, 8'hA5, 13, 0, 0, 1);
    chk("lit_write_count", wr_cnt - w0, 1);
    chk("lit_write_fields", {last_tgt, last_addr, last_wd}, {1'b0, 4'h5, 8'hA5});
    chk("lit_write_no_err", err_cnt - e0, 0);

    // Load dcache addr 3 <- 3C, then read it back over miso.
    frame(1'b1, 1'b1, 4'h3, 8'h3C, 13, 0, 0, 0);
    r0 = rd_cnt;
    frame(1'b0, 1'b1, 4'h3, 8'h00, 14, 0, 0, 1);
    chk("lit_read_count", rd_cnt - r0, 1);
    chk("lit_read_miso", miso_byte, 8'h3C);

    // Abort after 9 bits.
    w0 = wr_cnt; e0 = err_cnt;
    frame(1'b1, 1'b0, 4'h7, 8'h11, 9, 0, 0, 1);
    chk("lit_abort_err", err_cnt - e0, 1);
    chk("lit_abort_no_wr", wr_cnt - w0, 0);
    chk("lit_abort_idle", host_busy, 0);

    // Contention, then a normal write.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    frame(1'b1, 1'b0, 4'h2, 8'h99, 4, 3, 0, 1);
    chk("lit_contention_err", err_cnt - e0, 1);
    chk("lit_contention_no_access", (wr_cnt - w0) + (rd_cnt - r0), 0);
    frame(1'b1, 1'b0, 4'h2, 8'h66, 13, 0, 0, 1);
    chk("lit_after_contention_wr", {last_addr, last_wd}, {4'h2, 8'h66});

    // Refusal while the processor runs.
    w0 = wr_cnt; e0 = err_cnt;
    frame(1'b1, 1'b1, 4'h4, 8'h77, 13, 2, 0, 1);
    chk("lit_refuse_err", err_cnt - e0, 1);
    chk("lit_refuse_no_wr", wr_cnt - w0, 0);

    // Reset after 10 bits, then a full write of F <- 81.
    w0 = wr_cnt;
    e = cyc + 1;
    rbits = {1'b1, 4'hC, 8'hF0};
    for (int o = 0; o < 10; o++) begin
      if (o > 0) exp_busy[e+o-1] = 1'b1;
      step(1'b0, 1'b1, rbits[12-o], 1'b0);
    end
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 4'hF, 8'h81, 13, 0, 0, 1);
    chk("lit_reset_one_write", wr_cnt - w0, 1);
    chk("lit_reset_write_fields", {last_addr, last_wd}, {4'hF, 8'h81});

    // Randomized frames of every kind.
    for (int i = 0; i < 220 && cyc < MAXC - 64; i++) begin
      int kind, need, n, m;
      bit is_wr, tgt;
      kind  = $urandom_range(0, 9);
      is_wr = 1'($urandom_range(0, 1));
      tgt   = 1'($urandom_range(0, 1));
      need  = is_wr ? 13 : 14;
      m     = $urandom_range(2, 4);
      case (kind)
        0:       begin n = $urandom_range(1, 16);       frame(is_wr, tgt, 4'($urandom), 8'($urandom), n, 2, 0, $urandom_range(0, 2)); end
        1:       begin n = $urandom_range(1, 6);        frame(is_wr, tgt, 4'($urandom), 8'($urandom), n, 3, 0, $urandom_range(0, 2)); end
        2:       begin n = $urandom_range(1, need - 1); frame(is_wr, tgt, 4'($urandom), 8'($urandom), n, 0, 0, $urandom_range(0, 2)); end
        3:       begin n = $urandom_range(1, need - 1); frame(is_wr, tgt, 4'($urandom), 8'($urandom), n, 1, m, $urandom_range(0, 2)); end
        default: begin n = need + $urandom_range(0, 3); frame(is_wr, tgt, 4'($urandom), 8'($urandom), n, 0, 0, $urandom_range(0, 2)); end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
